// File: rtl/cceip_output_frame_buffer.sv
// -----------------------------------------------------------------------------
// cceip_output_frame_buffer
//
// Buffers one complete CCEIP output frame (64-bit beats) so the kernel control
// FSM can learn the frame's byte count before any payload is released. The
// control FSM writes the size word and then pulses drain_start. The stored
// words are then streamed out towards the AXI4 write master.
//
// Build option: define CCEIP_OUTBUF_KEEP_MASK_EN to zero the byte lanes whose
// tkeep bit is clear before storage. Without it, tdata is stored raw.
//
// Ports
//   ap_clk, areset        clock; synchronous active-high reset
//   s_axis_*              engine output stream (tdata/tkeep/tlast, valid/ready)
//   frame_size_valid      frame closed, frame_size is stable until drain_start
//   frame_size            true byte count of the frame (saturating)
//   overflow              frame exceeded capacity; stored data was truncated
//   drain_start           one-cycle pulse, honoured only while the size is shown
//   m_axis_*              drained words (tdata/tlast, valid/ready)
//   drain_done            one-cycle pulse the cycle after the final handshake
//   dbg_state             current FSM state (0 FILL, 1 SIZE, 2 DRAIN, 3 DONE)
//
// Handshake rule on both streams: a beat transfers on a rising edge where
// valid and ready are both high. On m_axis, valid is a register output that
// never looks at ready, and tdata/tlast stay put while valid is high and ready
// is low.
// -----------------------------------------------------------------------------
module cceip_output_frame_buffer #(
  parameter int DEPTH_LOG2 = 10,
  parameter int CNT_WIDTH  = 64
) (
  input  logic                 ap_clk,
  input  logic                 areset,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic [63:0]          s_axis_tdata,
  input  logic [7:0]           s_axis_tkeep,
  input  logic                 s_axis_tlast,
  output logic                 frame_size_valid,
  output logic [CNT_WIDTH-1:0] frame_size,
  output logic                 overflow,
  input  logic                 drain_start,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [63:0]          m_axis_tdata,
  output logic                 m_axis_tlast,
  output logic                 drain_done,
  output logic [1:0]           dbg_state
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_W = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   ONE_W  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] ONE_P  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_SIZE  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0]   stored_q, stored_d;   // words held, 0..DEPTH
  logic [DEPTH_LOG2:0]   rd_ptr_q, rd_ptr_d;   // next word index to fetch
  logic [CNT_WIDTH-1:0]  byte_cnt_q, byte_cnt_d;
  logic                  overflow_q, overflow_d;

  // Read pipeline: RAM output stage, then output register plus skid entry.
  logic                  rd_vld_q, rd_vld_d;
  logic                  rd_last_q, rd_last_d;
  logic [63:0]           ram_q;
  logic                  out_vld_q, out_vld_d;
  logic                  out_last_q, out_last_d;
  logic [63:0]           out_data_q, out_data_d;
  logic                  skid_vld_q, skid_vld_d;
  logic                  skid_last_q, skid_last_d;
  logic [63:0]           skid_data_q, skid_data_d;

  logic [63:0]           mem [DEPTH];
  logic                  mem_we;
  logic [63:0]           mem_wdata;
  logic                  rd_en;
  logic [DEPTH_LOG2-1:0] rd_addr;

  logic [3:0]            keep_cnt;
  logic [CNT_WIDTH:0]    cnt_sum;
  logic                  full;
  logic                  pop;
  logic [1:0]            in_flight;
  logic                  credit_ok;
  logic                  issue;
  logic [DEPTH_LOG2:0]   rd_ptr_inc;

  // Byte count of the beat; lanes are contiguous but a plain popcount is
  // just as cheap and tolerates a misbehaving engine.
  always_comb begin
    keep_cnt = 4'd0;
    for (int i = 0; i < 8; i++) begin
      keep_cnt = keep_cnt + {3'b000, s_axis_tkeep[i]};
    end
  end

  // One spare bit catches the carry so the counter can saturate.
  assign cnt_sum = {1'b0, byte_cnt_q} + {{(CNT_WIDTH-3){1'b0}}, keep_cnt};

`ifdef CCEIP_OUTBUF_KEEP_MASK_EN
  always_comb begin
    mem_wdata = 64'd0;
    for (int i = 0; i < 8; i++) begin
      mem_wdata[8*i +: 8] = s_axis_tkeep[i] ? s_axis_tdata[8*i +: 8] : 8'h00;
    end
  end
`else
  assign mem_wdata = s_axis_tdata;
`endif

  assign full       = (stored_q == FULL_W);
  assign pop        = out_vld_q & m_axis_tready;
  assign in_flight  = {1'b0, rd_vld_q} + {1'b0, out_vld_q} + {1'b0, skid_vld_q};
  // A fetch may start only if, after this cycle's pop, the output register and
  // skid entry together still have room for every word already in flight.
  assign credit_ok  = (in_flight - {1'b0, pop}) < 2'd2;
  assign rd_ptr_inc = rd_ptr_q + ONE_W;
  assign rd_addr    = rd_ptr_q[DEPTH_LOG2-1:0];

  // Control FSM: next state, pointers, counters and the fetch request.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    stored_d   = stored_q;
    rd_ptr_d   = rd_ptr_q;
    byte_cnt_d = byte_cnt_q;
    overflow_d = overflow_q;
    mem_we     = 1'b0;
    issue      = 1'b0;
    unique case (state_q)
      S_FILL: begin
        if (s_axis_tvalid) begin
          if (s_axis_tkeep != 8'h00) begin
            byte_cnt_d = cnt_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : cnt_sum[CNT_WIDTH-1:0];
            if (full) begin
              overflow_d = 1'b1;
            end else begin
              mem_we   = 1'b1;
              wr_ptr_d = wr_ptr_q + ONE_P;
              stored_d = stored_q + ONE_W;
            end
          end
          if (s_axis_tlast) state_d = S_SIZE;
        end
      end
      S_SIZE: begin
        // rd_ptr is already zero here (cleared in S_DONE and by reset), so the
        // first fetch is launched in the drain_start cycle itself.
        if (drain_start) begin
          if (stored_q == '0) begin
            state_d = S_DONE;
          end else begin
            issue   = 1'b1;
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if ((rd_ptr_q != stored_q) && credit_ok) issue = 1'b1;
        if (pop && out_last_q) state_d = S_DONE;
      end
      S_DONE: begin
        wr_ptr_d   = '0;
        stored_d   = '0;
        rd_ptr_d   = '0;
        byte_cnt_d = '0;
        overflow_d = 1'b0;
        state_d    = S_FILL;
      end
      default: state_d = S_FILL;
    endcase
    if (issue) rd_ptr_d = rd_ptr_inc;
  end

  assign rd_en     = issue;
  assign rd_vld_d  = issue;
  assign rd_last_d = issue & (rd_ptr_inc == stored_q);

  // Output register with one-entry skid: the RAM word lands in the output
  // register when it is free or draining, otherwise in the skid entry.
  always_comb begin
    out_vld_d   = out_vld_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    skid_vld_d  = skid_vld_q;
    skid_last_d = skid_last_q;
    skid_data_d = skid_data_q;
    if (!out_vld_q || pop) begin
      if (skid_vld_q) begin
        out_vld_d   = 1'b1;
        out_last_d  = skid_last_q;
        out_data_d  = skid_data_q;
        skid_vld_d  = rd_vld_q;
        skid_last_d = rd_last_q;
        skid_data_d = ram_q;
      end else if (rd_vld_q) begin
        out_vld_d  = 1'b1;
        out_last_d = rd_last_q;
        out_data_d = ram_q;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (rd_vld_q) begin
      skid_vld_d  = 1'b1;
      skid_last_d = rd_last_q;
      skid_data_d = ram_q;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state_q     <= S_FILL;
      wr_ptr_q    <= '0;
      stored_q    <= '0;
      rd_ptr_q    <= '0;
      byte_cnt_q  <= '0;
      overflow_q  <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_last_q   <= 1'b0;
      out_vld_q   <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= 64'd0;
      skid_vld_q  <= 1'b0;
      skid_last_q <= 1'b0;
      skid_data_q <= 64'd0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      stored_q    <= stored_d;
      rd_ptr_q    <= rd_ptr_d;
      byte_cnt_q  <= byte_cnt_d;
      overflow_q  <= overflow_d;
      rd_vld_q    <= rd_vld_d;
      rd_last_q   <= rd_last_d;
      out_vld_q   <= out_vld_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      skid_vld_q  <= skid_vld_d;
      skid_last_q <= skid_last_d;
      skid_data_q <= skid_data_d;
    end
  end

  // Block RAM: no reset, synchronous read.
  always_ff @(posedge ap_clk) begin
    if (mem_we) mem[wr_ptr_q] <= mem_wdata;
    if (rd_en)  ram_q <= mem[rd_addr];
  end

  assign s_axis_tready    = (state_q == S_FILL);
  assign frame_size_valid = (state_q == S_SIZE);
  assign frame_size       = frame_size_valid ? byte_cnt_q : '0;
  assign overflow         = overflow_q;
  assign m_axis_tvalid    = out_vld_q;
  assign m_axis_tdata     = out_data_q;
  assign m_axis_tlast     = out_vld_q & out_last_q;
  assign drain_done       = (state_q == S_DONE);
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_cceip_output_frame_buffer.sv
// -----------------------------------------------------------------------------
// Bench for cceip_output_frame_buffer. Two instances share clock and reset:
// index 0 uses the default depth (1024 words), index 1 uses DEPTH_LOG2 = 2
// (4 words) so truncation is reachable with short frames. The reference model
// describes a frame as a list of beats and derives the byte total, the overflow
// flag and the list of words that must come out of the drain.
// -----------------------------------------------------------------------------
module tb_cceip_output_frame_buffer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic areset;
  always #5 clk = ~clk;

  logic        s_tvalid [2];
  logic        s_tready [2];
  logic [63:0] s_tdata  [2];
  logic [7:0]  s_tkeep  [2];
  logic        s_tlast  [2];
  logic        fsv      [2];
  logic [63:0] fsize    [2];
  logic        ovf      [2];
  logic        dstart   [2];
  logic        m_tvalid [2];
  logic        m_tready [2];
  logic [63:0] m_tdata  [2];
  logic        m_tlast  [2];
  logic        ddone    [2];
  logic [1:0]  dbg      [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    cceip_output_frame_buffer #(
      .DEPTH_LOG2 (g == 0 ? 10 : 2),
      .CNT_WIDTH  (64)
    ) dut (
      .ap_clk           (clk),
      .areset           (areset),
      .s_axis_tvalid    (s_tvalid[g]),
      .s_axis_tready    (s_tready[g]),
      .s_axis_tdata     (s_tdata[g]),
      .s_axis_tkeep     (s_tkeep[g]),
      .s_axis_tlast     (s_tlast[g]),
      .frame_size_valid (fsv[g]),
      .frame_size       (fsize[g]),
      .overflow         (ovf[g]),
      .drain_start      (dstart[g]),
      .m_axis_tvalid    (m_tvalid[g]),
      .m_axis_tready    (m_tready[g]),
      .m_axis_tdata     (m_tdata[g]),
      .m_axis_tlast     (m_tlast[g]),
      .drain_done       (ddone[g]),
      .dbg_state        (dbg[g])
    );
  end

  // ---------------- scoreboard / model state ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] exp_q [$];      // words the drain must produce, in order
  logic [63:0] tx_d  [$];      // beats of the frame under construction
  logic [7:0]  tx_k  [$];
  logic [63:0] exp_bytes;
  logic        exp_ovf;
  int          exp_words;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int capacity(input int sel);
    return (sel == 0) ? 1024 : 4;
  endfunction

  function automatic logic [63:0] model_word(input logic [63:0] d, input int n);
`ifdef CCEIP_OUTBUF_KEEP_MASK_EN
    logic [63:0] m;
    m = (n >= 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * n)) - 64'd1);
    return d & m;
`else
    return d;
`endif
  endfunction

  task automatic new_frame();
    tx_d.delete();
    tx_k.delete();
    exp_q.delete();
    exp_bytes = 64'd0;
    exp_ovf   = 1'b0;
    exp_words = 0;
  endtask

  // Append a beat carrying n valid bytes (lanes 0..n-1) and update the model.
  task automatic add_beat(input int sel, input logic [63:0] d, input int n);
    logic [8:0] t;
    t = (9'd1 << n) - 9'd1;
    tx_d.push_back(d);
    tx_k.push_back(t[7:0]);
    exp_bytes = exp_bytes + 64'(n);
    if (n > 0) begin
      if (exp_words < capacity(sel)) begin
        exp_q.push_back(model_word(d, n));
        exp_words++;
      end else begin
        exp_ovf = 1'b1;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_frame(input int sel, input bit gaps);
    int hold;
    for (int i = 0; i < tx_d.size(); i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) step();
      end
      chk("fill_ready", {63'd0, s_tready[sel]}, 64'd1);
      chk("fill_fsv_low", {63'd0, fsv[sel]}, 64'd0);
      s_tvalid[sel] = 1'b1;
      s_tdata[sel]  = tx_d[i];
      s_tkeep[sel]  = tx_k[i];
      s_tlast[sel]  = (i == tx_d.size() - 1);
      step();
      s_tvalid[sel] = 1'b0;
      s_tlast[sel]  = 1'b0;
      s_tkeep[sel]  = 8'h00;
    end
    // The cycle right after the tlast handshake.
    chk("fsv_rise", {63'd0, fsv[sel]}, 64'd1);
    chk("frame_size", fsize[sel], exp_bytes);
    chk("overflow", {63'd0, ovf[sel]}, {63'd0, exp_ovf});
    chk("size_ready_low", {63'd0, s_tready[sel]}, 64'd0);
    hold = $urandom_range(0, 3);
    for (int i = 0; i < hold; i++) begin
      step();
      chk("fsv_hold", {63'd0, fsv[sel]}, 64'd1);
      chk("size_hold", fsize[sel], exp_bytes);
    end
  endtask

  task automatic drain_frame(input int sel, input bit bp);
    int          cyc;
    bit          seen_vld;
    bit          stalled;
    logic [63:0] hold_d;
    logic        hold_l;
    logic [63:0] want;
    dstart[sel] = 1'b1;
    step();
    dstart[sel] = 1'b0;
    cyc = 1;
    if (exp_q.size() == 0) begin
      chk("zero_done", {63'd0, ddone[sel]}, 64'd1);
      chk("zero_no_vld", {63'd0, m_tvalid[sel]}, 64'd0);
      step();
      chk("zero_done_pulse", {63'd0, ddone[sel]}, 64'd0);
      chk("zero_back_fill", {63'd0, s_tready[sel]}, 64'd1);
      return;
    end
    seen_vld = 1'b0;
    stalled  = 1'b0;
    hold_d   = 64'd0;
    hold_l   = 1'b0;
    while (exp_q.size() > 0 && cyc < 4000) begin
      m_tready[sel] = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      chk("done_low_in_drain", {63'd0, ddone[sel]}, 64'd0);
      if (stalled) begin
        chk("stall_vld_hold", {63'd0, m_tvalid[sel]}, 64'd1);
        chk("stall_data_hold", m_tdata[sel], hold_d);
        chk("stall_last_hold", {63'd0, m_tlast[sel]}, {63'd0, hold_l});
      end
      if (m_tvalid[sel]) begin
        if (!seen_vld) begin
          seen_vld = 1'b1;
          chk("first_vld_latency", 64'(cyc), 64'd2);
        end
        if (m_tready[sel]) begin
          want = exp_q.pop_front();
          chk("drain_data", m_tdata[sel], want);
          chk("drain_last", {63'd0, m_tlast[sel]}, {63'd0, exp_q.size() == 0});
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          hold_d  = m_tdata[sel];
          hold_l  = m_tlast[sel];
        end
      end
      step();
      cyc++;
    end
    if (exp_q.size() > 0) begin
      chk("drain_timeout_words_left", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
    m_tready[sel] = 1'b0;
    chk("drain_done_pulse", {63'd0, ddone[sel]}, 64'd1);
    chk("no_extra_word", {63'd0, m_tvalid[sel]}, 64'd0);
    step();
    chk("drain_done_once", {63'd0, ddone[sel]}, 64'd0);
    chk("back_to_fill", {63'd0, s_tready[sel]}, 64'd1);
    chk("overflow_cleared", {63'd0, ovf[sel]}, 64'd0);
    chk("fsv_cleared", {63'd0, fsv[sel]}, 64'd0);
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int hs;
    int len;
    for (int s = 0; s < 2; s++) begin
      s_tvalid[s] = 1'b0;
      s_tdata[s]  = 64'd0;
      s_tkeep[s]  = 8'h00;
      s_tlast[s]  = 1'b0;
      dstart[s]   = 1'b0;
      m_tready[s] = 1'b0;
    end
    areset = 1'b1;
    step();
    step();
    for (int s = 0; s < 2; s++) begin
      chk("rst_s_tready", {63'd0, s_tready[s]}, 64'd1);
      chk("rst_fsv", {63'd0, fsv[s]}, 64'd0);
      chk("rst_frame_size", fsize[s], 64'd0);
      chk("rst_overflow", {63'd0, ovf[s]}, 64'd0);
      chk("rst_m_tvalid", {63'd0, m_tvalid[s]}, 64'd0);
      chk("rst_m_tlast", {63'd0, m_tlast[s]}, 64'd0);
      chk("rst_drain_done", {63'd0, ddone[s]}, 64'd0);
      chk("rst_m_tdata", m_tdata[s], 64'd0);
    end
    areset = 1'b0;
    step();

    // drain_start while filling is ignored
    dstart[0] = 1'b1;
    step();
    dstart[0] = 1'b0;
    step();
    chk("ign_start_vld", {63'd0, m_tvalid[0]}, 64'd0);
    chk("ign_start_ready", {63'd0, s_tready[0]}, 64'd1);
    chk("ign_start_done", {63'd0, ddone[0]}, 64'd0);

    // basic frame: FF, FF, 0F+last -> 20 bytes, 3 words
    new_frame();
    add_beat(0, rand64(), 8);
    add_beat(0, rand64(), 8);
    add_beat(0, rand64(), 4);
    send_frame(0, 1'b0);
    chk("basic_size", fsize[0], 64'd20);
    drain_frame(0, 1'b0);

    // overflow on the 4-word instance: 6 full beats
    new_frame();
    for (int i = 0; i < 6; i++) add_beat(1, rand64(), 8);
    send_frame(1, 1'b0);
    chk("ovf_flag", {63'd0, ovf[1]}, 64'd1);
    chk("ovf_size", fsize[1], 64'd48);
    drain_frame(1, 1'b0);

    // 16-word frame with random backpressure
    new_frame();
    for (int i = 0; i < 16; i++) add_beat(0, rand64(), 8);
    send_frame(0, 1'b1);
    drain_frame(0, 1'b1);

    // zero-byte frame
    new_frame();
    add_beat(0, rand64(), 0);
    send_frame(0, 1'b0);
    chk("zero_size", fsize[0], 64'd0);
    drain_frame(0, 1'b0);

    // keep mask
    new_frame();
    add_beat(0, 64'h1122_3344_5566_7788, 4);
`ifdef CCEIP_OUTBUF_KEEP_MASK_EN
    chk("mask_model", exp_q[0], 64'h0000_0000_5566_7788);
`else
    chk("mask_model", exp_q[0], 64'h1122_3344_5566_7788);
`endif
    send_frame(0, 1'b0);
    drain_frame(0, 1'b0);

    // reset after the second word of a 5-word drain
    new_frame();
    for (int i = 0; i < 5; i++) add_beat(0, rand64(), 8);
    send_frame(0, 1'b0);
    dstart[0] = 1'b1;
    step();
    dstart[0] = 1'b0;
    hs = 0;
    for (int c = 0; c < 20 && hs < 2; c++) begin
      m_tready[0] = 1'b1;
      if (m_tvalid[0]) begin
        chk("rst_drain_data", m_tdata[0], exp_q.pop_front());
        hs++;
      end
      step();
    end
    chk("rst_drain_two_words", 64'(hs), 64'd2);
    areset = 1'b1;
    step();
    areset = 1'b0;
    m_tready[0] = 1'b0;
    chk("midrst_m_tvalid", {63'd0, m_tvalid[0]}, 64'd0);
    chk("midrst_s_tready", {63'd0, s_tready[0]}, 64'd1);
    chk("midrst_fsv", {63'd0, fsv[0]}, 64'd0);
    new_frame();
    add_beat(0, rand64(), 5);
    send_frame(0, 1'b0);
    chk("post_rst_size", fsize[0], 64'd5);
    drain_frame(0, 1'b1);

    // random frames on both instances
    for (int f = 0; f < 10; f++) begin
      int sel;
      sel = (f % 3 == 2) ? 1 : 0;
      len = (sel == 0) ? $urandom_range(1, 20) : $urandom_range(1, 8);
      new_frame();
      for (int i = 0; i < len; i++) add_beat(sel, rand64(), $urandom_range(0, 8));
      send_frame(sel, 1'b1);
      drain_frame(sel, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
